// File: rtl/spi_slave_responder.sv
// SPI responder that oversamples ss/sclk/mosi in the wb_clk_i domain and shifts
// one DATA_W-bit word each way per frame, using a one-entry transmit holding buffer.
module spi_slave_responder #(
  parameter int unsigned       DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_WORD = '1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ss_pad_i,
  input  logic              sclk_pad_i,
  input  logic              mosi_pad_i,
  output logic              miso_pad_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              tx_underrun_o,
  output logic              frame_abort_o
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ss_q, sclk_q;
  logic [1:0]        mosi_q;
  logic              buf_full_q;
  logic [DATA_W-1:0] buf_q, tx_sh_q, rx_sh_q, rx_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              miso_q, rx_valid_q;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // [0],[1] synchronize; [2] is the history flop used for edge detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ss_q   <= 3'b111;
      sclk_q <= {3{CPOL}};
      mosi_q <= '0;
    end else begin
      ss_q   <= {ss_q[1:0], ss_pad_i};
      sclk_q <= {sclk_q[1:0], sclk_pad_i};
      mosi_q <= {mosi_q[0], mosi_pad_i};
    end
  end

  logic ss_s, ss_fall, sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, launch_edge;
  logic in_shift, word_done, sample_ok, do_launch;
  logic [DATA_W-1:0] rx_next, load_word;

  assign ss_s        = ss_q[1];
  assign ss_fall     = ss_q[2] & ~ss_q[1];
  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign launch_edge = CPHA ? lead_edge : trail_edge;

  assign in_shift  = (state_q == ST_SHIFT);
  // A deselect coinciding with the final sample still completes the word
  assign word_done = in_shift && sample_edge && (cnt_q == LAST_BIT);
  assign sample_ok = in_shift && sample_edge && (!ss_s || cnt_q == LAST_BIT);
  assign do_launch = in_shift && launch_edge && !ss_s && (CPHA || cnt_q != '0);
  assign rx_next   = MSB_FIRST ? DATA_W'({rx_sh_q, mosi_q[1]})
                               : DATA_W'({mosi_q[1], rx_sh_q} >> 1);
  assign load_word = buf_full_q ? buf_q : IDLE_WORD;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (word_done)  state_d = ss_s ? ST_IDLE : ST_LOAD;
        else if (ss_s)  state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    miso_oe_o     = (state_q != ST_IDLE);
    tx_underrun_o = (state_q == ST_LOAD) && !buf_full_q && !wb_rst_i;
    frame_abort_o = in_shift && ss_s && !word_done && (cnt_q != '0) && !wb_rst_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else if (state_q == ST_LOAD && buf_full_q) begin
      buf_full_q <= 1'b0;
    end else if (tx_valid_i && !buf_full_q) begin
      buf_full_q <= 1'b1;
      buf_q      <= tx_data_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          cnt_q <= '0;
          if (CPHA) begin
            tx_sh_q <= load_word;
          end else begin
            miso_q  <= first_bit(load_word);
            tx_sh_q <= shift_out(load_word);
          end
        end
        ST_SHIFT: begin
          if (sample_ok) begin
            rx_sh_q <= rx_next;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
          if (word_done) begin
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
            cnt_q      <= '0;
          end else if (ss_s) begin
            cnt_q <= '0;
          end
          if (do_launch) begin
            miso_q  <= first_bit(tx_sh_q);
            tx_sh_q <= shift_out(tx_sh_q);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign miso_pad_o = miso_q;
  assign tx_ready_o = ~buf_full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = ~ss_s;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Drives five responders (four CPOL/CPHA modes LSB-first, plus mode 0 MSB-first)
// from one SPI master model and checks them against a word-level reference.
`timescale 1ns/1ps
module tb_spi_slave_responder;
  localparam int N = 5;
  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         ss;
  logic [N-1:0] sclk, mosi, miso, oe, txv, txr, rxv, busy, und, abt;
  logic [W-1:0] txd [N];
  logic [W-1:0] rxd [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_slave_responder #(
      .DATA_W(W), .CPOL(bit'((g >> 1) & 1)), .CPHA(bit'(g & 1)),
      .MSB_FIRST(bit'(g == 4)), .IDLE_WORD({W{1'b1}})
    ) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .ss_pad_i(ss), .sclk_pad_i(sclk[g]),
      .mosi_pad_i(mosi[g]), .miso_pad_o(miso[g]), .miso_oe_o(oe[g]),
      .tx_data_i(txd[g]), .tx_valid_i(txv[g]), .tx_ready_o(txr[g]),
      .rx_data_o(rxd[g]), .rx_valid_o(rxv[g]), .busy_o(busy[g]),
      .tx_underrun_o(und[g]), .frame_abort_o(abt[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_rx   [N][$];
  logic [W-1:0] exp_miso [N][$];
  logic [W-1:0] last_rx  [N];
  logic [N-1:0] buf_full_m;
  logic [W-1:0] buf_val  [N];
  int           und_cyc  [N] = '{default: 0};
  int           abt_cyc  [N] = '{default: 0};
  int           exp_und  [N] = '{default: 0};
  int           exp_abt  [N] = '{default: 0};
  logic [W-1:0] mtx [N][2];
  logic [W-1:0] mrx [N][2];
  logic [W-1:0] wv  [N];

  function automatic bit cpol(input int i); return bit'((i >> 1) & 1); endfunction
  function automatic bit cpha(input int i); return bit'(i & 1); endfunction
  function automatic int pos(input int i, input int k); return (i == 4) ? W - 1 - k : k; endfunction

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level reference: which word each frame load must pick up
  task automatic model_load(input int i);
    if (buf_full_m[i]) begin
      exp_miso[i].push_back(buf_val[i]);
      buf_full_m[i] = 1'b0;
    end else begin
      exp_miso[i].push_back({W{1'b1}});
      exp_und[i]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) last_rx[i] = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        und_cyc[i] += int'(und[i]);
        abt_cyc[i] += int'(abt[i]);
        if (rxv[i]) begin
          if (exp_rx[i].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_unexpected[%0d]: got pulse with data %0h, required no pulse", i, rxd[i]);
          end else begin
            check("rx_data", i, 32'(rxd[i]), 32'(exp_rx[i][0]));
            last_rx[i] = exp_rx[i].pop_front();
          end
        end else begin
          check("rx_hold", i, 32'(rxd[i]), 32'(last_rx[i]));
        end
      end
    end
  end

  task automatic chk_reset();
    for (int i = 0; i < N; i++) begin
      check("rst_miso", i, 32'(miso[i]), 0);
      check("rst_oe", i, 32'(oe[i]), 0);
      check("rst_txr", i, 32'(txr[i]), 1);
      check("rst_rxd", i, 32'(rxd[i]), 0);
      check("rst_rxv", i, 32'(rxv[i]), 0);
      check("rst_busy", i, 32'(busy[i]), 0);
      check("rst_und", i, 32'(und[i]), 0);
      check("rst_abt", i, 32'(abt[i]), 0);
    end
  endtask

  task automatic tx_write(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) check("tx_ready_pre", i, 32'(txr[i]), 32'(!buf_full_m[i]));
      txd[i] = wv[i];
    end
    txv = mask;
    tick();
    txv = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        buf_full_m[i] = 1'b1;
        buf_val[i]    = wv[i];
        check("tx_ready_post", i, 32'(txr[i]), 0);
      end
    end
  endtask

  // endm: 0 = ss rises with the last sample edge, 1 = ss rises later, 2 = reset mid-frame
  task automatic frame(input int nbits, input int endm, input bit mid_wr);
    ss = 1'b0;
    for (int i = 0; i < N; i++) model_load(i);
    repeat (H) tick();
    for (int b = 0; b < nbits; b++) begin
      int k, wd;
      k  = b % W;
      wd = b / W;
      for (int i = 0; i < N; i++) begin
        mosi[i] = mtx[i][wd][pos(i, k)];
        sclk[i] = cpha(i) ? ~cpol(i) : cpol(i);
      end
      repeat (H) tick();
      for (int i = 0; i < N; i++) begin
        sclk[i] = cpha(i) ? cpol(i) : ~cpol(i);
        mrx[i][wd][pos(i, k)] = miso[i];
        if (k == W - 1) exp_rx[i].push_back(mtx[i][wd]);
        if (b == 1) begin
          check("oe_mid", i, 32'(oe[i]), 1);
          check("busy_mid", i, 32'(busy[i]), 1);
          check("txr_mid", i, 32'(txr[i]), 32'(!buf_full_m[i]));
        end
      end
      if (b == nbits - 1 && endm == 0) ss = 1'b1;
      repeat (H) tick();
      if (k == W - 1 && b != nbits - 1) for (int i = 0; i < N; i++) model_load(i);
      if (mid_wr && b == 4) tx_write('1);
    end
    for (int i = 0; i < N; i++) sclk[i] = cpol(i);
    repeat (H) tick();
    if (endm == 1) begin
      for (int i = 0; i < N; i++) begin
        if (nbits % W == 0) model_load(i);
        else exp_abt[i]++;
      end
      ss = 1'b1;
    end else if (endm == 2) begin
      rst = 1'b1;
      tick();
      chk_reset();
      rst = 1'b0;
      ss  = 1'b1;
      buf_full_m = '0;
    end
    repeat (2 * H) tick();
    for (int i = 0; i < N; i++) begin
      check("oe_idle", i, 32'(oe[i]), 0);
      check("busy_idle", i, 32'(busy[i]), 0);
      check("txr_idle", i, 32'(txr[i]), 32'(!buf_full_m[i]));
      check("und_count", i, 32'(und_cyc[i]), 32'(exp_und[i]));
      check("abt_count", i, 32'(abt_cyc[i]), 32'(exp_abt[i]));
      check("rx_pending", i, 32'(exp_rx[i].size()), 0);
      for (int wd = 0; wd < nbits / W; wd++)
        check("miso_word", i, 32'(mrx[i][wd]), 32'(exp_miso[i].pop_front()));
      exp_miso[i].delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    ss  = 1'b1;
    txv = '0;
    mosi = '0;
    buf_full_m = '0;
    for (int i = 0; i < N; i++) begin
      sclk[i] = cpol(i);
      txd[i]  = '0;
    end
    repeat (3) tick();
    chk_reset();
    rst = 1'b0;
    repeat (4) tick();

    // Full duplex: mode 0 MSB-first A5/3C, other modes LSB-first 81/01
    for (int i = 0; i < N; i++) begin
      wv[i]     = (i == 4) ? 8'hA5 : 8'h81;
      mtx[i][0] = (i == 4) ? 8'h3C : 8'h01;
    end
    tx_write('1);
    frame(W, 0, 1'b0);
    check("pin_miso_a5", 4, 32'(mrx[4][0]), 32'h A5);
    check("pin_rx_3c", 4, 32'(rxd[4]), 32'h3C);
    for (int i = 0; i < 4; i++) begin
      check("pin_miso_81", i, 32'(mrx[i][0]), 32'h81);
      check("pin_rx_01", i, 32'(rxd[i]), 32'h01);
      check("pin_no_und", i, 32'(und_cyc[i]), 0);
    end

    // Empty buffer
    for (int i = 0; i < N; i++) mtx[i][0] = 8'h55;
    frame(W, 0, 1'b0);
    for (int i = 0; i < N; i++) begin
      check("pin_idle_word", i, 32'(mrx[i][0]), 32'hFF);
      check("pin_und_once", i, 32'(und_cyc[i]), 1);
      check("pin_rx_55", i, 32'(rxd[i]), 32'h55);
    end

    // Back-to-back frames with a mid-frame write
    for (int i = 0; i < N; i++) begin
      wv[i]     = 8'h12;
      mtx[i][0] = W'($urandom);
      mtx[i][1] = W'($urandom);
    end
    tx_write('1);
    for (int i = 0; i < N; i++) wv[i] = 8'h34;
    frame(2 * W, 0, 1'b1);
    for (int i = 0; i < N; i++) begin
      check("pin_b2b_0", i, 32'(mrx[i][0]), 32'h12);
      check("pin_b2b_1", i, 32'(mrx[i][1]), 32'h34);
      check("pin_b2b_und", i, 32'(und_cyc[i]), 1);
    end

    // Abort after 5 samples, then a full frame with an empty buffer
    for (int i = 0; i < N; i++) begin
      wv[i]     = W'($urandom);
      mtx[i][0] = W'($urandom);
    end
    tx_write('1);
    frame(5, 1, 1'b0);
    for (int i = 0; i < N; i++) check("pin_abort_once", i, 32'(abt_cyc[i]), 1);
    frame(W, 0, 1'b0);
    for (int i = 0; i < N; i++) check("pin_after_abort", i, 32'(mrx[i][0]), 32'hFF);

    // Reset mid-frame, then a normal frame
    for (int i = 0; i < N; i++) wv[i] = W'($urandom);
    tx_write('1);
    frame(3, 2, 1'b0);
    for (int i = 0; i < N; i++) begin
      wv[i]     = W'($urandom);
      mtx[i][0] = W'($urandom);
    end
    tx_write('1);
    frame(W, 0, 1'b0);

    // Randomized frames
    repeat (10) begin
      int kind;
      kind = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        wv[i]     = W'($urandom);
        mtx[i][0] = W'($urandom);
        mtx[i][1] = W'($urandom);
      end
      tx_write(N'($urandom));
      for (int i = 0; i < N; i++) wv[i] = W'($urandom);
      case (kind)
        0:       frame(W, 0, 1'b0);
        1:       frame(W, 1, 1'b0);
        2:       frame(2 * W, $urandom_range(0, 1), 1'b1);
        default: frame($urandom_range(1, W - 1), 1, 1'b0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI slave (responder) that sits on the pad side of the SPI master link, facing ss_pad_o/sclk_pad_o/mosi_pad_o and driving miso_pad_i.
- Runs entirely in the wb_clk_i domain and oversamples the SPI pins.
- Shifts a DATA_W-bit word in from MOSI and out on MISO per frame, with a one-entry transmit holding buffer and a receive-word strobe.
- Used as the synthesizable remote end in SPI loopback and system simulations.

Parameters:
- DATA_W, 8, bits per frame; legal 1..32.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first.
- IDLE_WORD, all ones, word transmitted when the tx buffer is empty at frame load.

Ports:
- wb_clk_i  input  1  system clock; all logic on its rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- ss_pad_i  input  1  slave select, active low, asynchronous to wb_clk_i.
- sclk_pad_i  input  1  SPI clock, asynchronous.
- mosi_pad_i  input  1  master-out data, asynchronous.
- miso_pad_o  output  1  slave-out data.
- miso_oe_o  output  1  MISO output enable; high only while selected.
- tx_data_i  input  DATA_W  next word to transmit.
- tx_valid_i  input  1  tx_data_i valid; accepted when tx_ready_o=1.
- tx_ready_o  output  1  tx holding buffer empty.
- rx_data_o  output  DATA_W  last complete received word; held until the next word completes.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
- busy_o  output  1  selected (synchronized ss low).
- tx_underrun_o  output  1  one-cycle pulse when a frame loads IDLE_WORD because the buffer is empty.
- frame_abort_o  output  1  one-cycle pulse when ss deasserts with 1..DATA_W-1 bits received.

Behaviour:
- **Reset values:** miso_pad_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, tx_underrun_o=0, frame_abort_o=0. Buffer empty, bit counter 0, state IDLE.
- **Reset mid-frame:** aborts the frame silently; no frame_abort_o pulse.
- **Input synchronization:** ss, sclk and mosi each pass through a 2-flop synchronizer, plus a history flop for edge detection.
  - Edge-to-internal-event latency: 3 wb_clk_i cycles.
  - Required: SCLK high and low phases each >= 4 wb_clk_i cycles; ss setup to first SCLK edge >= 4 cycles.
- **Edge definitions:**
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading when CPHA=0, trailing when CPHA=1.
  - Launch edge = the other edge.
- **Tx buffer:**
  - Write when tx_valid_i && tx_ready_o; tx_ready_o falls the next cycle.
  - Buffer is consumed at frame load; tx_ready_o rises the cycle after the load.
- **State machine:** IDLE -> LOAD -> SHIFT.
  - IDLE: miso_oe_o=0, counter 0. Synchronized ss falling -> LOAD.
  - LOAD (1 cycle): shift register <= buffer if full (buffer emptied), else IDLE_WORD with tx_underrun_o pulse. miso_oe_o=1.
    - CPHA=0: miso_pad_o = first bit in this cycle.
    - CPHA=1: miso_pad_o holds its previous value until the first leading edge.
    - -> SHIFT.
  - SHIFT:
    - Sample edge: capture the synchronized MOSI into the rx shift register; counter+1.
    - Launch edge: present the next tx bit on miso_pad_o. With CPHA=0, the trailing edge after the last sample of a frame does not launch.
    - When counter reaches DATA_W: rx_data_o <= assembled word and rx_valid_o pulses the following cycle; counter <= 0; next state LOAD if still selected (back-to-back frames).
    - Synchronized ss rising -> IDLE; miso_oe_o=0 next cycle. Partial rx discarded; frame_abort_o pulses if counter was 1..DATA_W-1. Transmit word already loaded is lost, not restored.
- **Bit order:** MSB_FIRST selects whether the shift direction takes and fills bit DATA_W-1 or bit 0 first. rx_data_o is always in natural bit order.
- **Simultaneous events:**
  - tx write in the same cycle as LOAD with an empty buffer: LOAD uses IDLE_WORD (underrun pulse); the written word is stored for the next frame.
  - ss rise in the same cycle as the DATA_W-th sample: the word completes (rx_valid_o pulses), no abort, -> IDLE.
- **SCLK while deselected:** edges with ss high are ignored and the counter is not advanced.

Test Plan:
- **Mode 0, DATA_W=8, full-duplex:** preload tx 0xA5; master sends 0x3C with SCLK period 16 cycles -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with a single rx_valid_o pulse; tx_ready_o=1 after load; no underrun.
- **All four CPOL/CPHA modes, MSB_FIRST=0:** tx 0x81, master sends 0x01 -> master receives 0x81 and rx_data_o=0x01 in every mode.
- **Empty buffer:** no preload, master sends 0x55 -> tx_underrun_o pulses once in LOAD; MISO = 0xFF; rx_data_o=0x55.
- **Back-to-back frames:** ss held low for 16 bits; tx 0x12, then 0x34 written mid-frame -> two rx_valid_o pulses; MISO 0x12 then 0x34; no underrun.
- **Abort:** ss rises after 5 sample edges -> frame_abort_o pulse; rx_valid_o stays 0; rx_data_o keeps its old value; miso_oe_o=0. The next full frame loads IDLE_WORD if the buffer is empty.
- **Reset mid-frame:** assert wb_rst_i after 3 bits -> all outputs at reset values next cycle, no abort pulse; the next frame after reset behaves normally.
